// File: rtl/word_serializer_if.sv
// Word-in / serial-out bus of the word serializer: push handshake plus the
// comEn/dataout pair that feeds the downstream per-clk receiver.
interface word_serializer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        dataout;
  logic        comEn;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  dataout,
    input  comEn
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output dataout,
    output comEn
  );
endinterface

// File: rtl/word_serializer.sv
// Buffers 32-bit words in a 4-deep FIFO and sends each one as a framed,
// MSB-first serial stream: one dummy lead slot, 32 data slots, one trail slot, then a gap.
module word_serializer #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  word_serializer_if.slave  bus,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       frame_count,
  output logic [2:0]        fifo_level
);

  localparam int SLOT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_e;

  state_e state_q, state_d;

  logic [31:0] fifoMem_q [4];
  logic [1:0]  wrPtr_q;
  logic [1:0]  rdPtr_q;
  logic [2:0]  level_q;
  logic        push;
  logic        pop;
  logic        fifoEmpty;

  logic [SLOT_W-1:0] slotCnt_q, slotCnt_d;
  logic [4:0]        bitCnt_q, bitCnt_d;
  logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;
  logic [31:0]       shift_q, shift_d;
  logic              slotEnd;

  logic        comEn_q, comEn_d;
  logic        dataout_q, dataout_d;
  logic        txDone_q, txDone_d;
  logic [15:0] frameCnt_q;

  assign fifoEmpty    = (level_q == 3'd0);
  assign bus.in_ready = (level_q < 3'd4);
  assign push         = bus.in_valid && bus.in_ready;
  assign slotEnd      = (slotCnt_q == SLOT_LAST);

  // FIFO pointers and occupancy; a same-edge push and pop leave the level alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= 2'd0;
      rdPtr_q <= 2'd0;
      level_q <= 3'd0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 2'd1;
      if (pop)  rdPtr_q <= rdPtr_q + 2'd1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 3'd1;
        2'b01:   level_q <= level_q - 3'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      slotCnt_q <= '0;
      bitCnt_q  <= 5'd0;
      gapCnt_q  <= '0;
      shift_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      slotCnt_q <= slotCnt_d;
      bitCnt_q  <= bitCnt_d;
      gapCnt_q  <= gapCnt_d;
      shift_q   <= shift_d;
    end
  end

  // The word is copied out of the FIFO at pop time, so later pushes cannot disturb it.
  always_comb begin
    state_d   = state_q;
    slotCnt_d = slotCnt_q;
    bitCnt_d  = bitCnt_q;
    gapCnt_d  = gapCnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    if (state_q != IDLE) begin
      slotCnt_d = slotEnd ? '0 : slotCnt_q + SLOT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shift_d   = fifoMem_q[rdPtr_q];
          slotCnt_d = '0;
          state_d   = LEAD;
        end
      end
      LEAD: begin
        if (slotEnd) begin
          bitCnt_d = 5'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (slotEnd) begin
          if (bitCnt_q == 5'd31) begin
            state_d = TRAIL;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
            shift_d  = {shift_q[30:0], 1'b0};
          end
        end
      end
      TRAIL: begin
        if (slotEnd) begin
          gapCnt_d = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (slotEnd) begin
          if (gapCnt_q == GAP_LAST) begin
            if (!fifoEmpty) begin
              pop     = 1'b1;
              shift_d = fifoMem_q[rdPtr_q];
              state_d = LEAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gapCnt_d = gapCnt_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the serial pins come straight off flops.
  always_comb begin
    comEn_d   = (state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL);
    dataout_d = (state_d == SHIFT) && shift_d[31];
    txDone_d  = (state_q == TRAIL) && (state_d == GAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comEn_q    <= 1'b0;
      dataout_q  <= 1'b0;
      txDone_q   <= 1'b0;
      frameCnt_q <= 16'd0;
    end else begin
      comEn_q   <= comEn_d;
      dataout_q <= dataout_d;
      txDone_q  <= txDone_d;
      if (txDone_d) frameCnt_q <= frameCnt_q + 16'd1;
    end
  end

  assign bus.comEn   = comEn_q;
  assign bus.dataout = dataout_q;
  assign busy        = (state_q != IDLE);
  assign tx_done     = txDone_q;
  assign frame_count = frameCnt_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus a random push
// stream, checked against a frame-level receiver and FIFO occupancy model.
module tb_word_serializer;

  localparam int GAP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  word_serializer_if bus ();
  word_serializer_if bus3 ();

  logic        busy, tx_done;
  logic [15:0] frame_count;
  logic [2:0]  fifo_level;
  logic        busy3, tx_done3;
  logic [15:0] frame_count3;
  logic [2:0]  fifo_level3;

  word_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .tx_done     (tx_done),
    .frame_count (frame_count),
    .fifo_level  (fifo_level)
  );

  word_serializer #(.BIT_CYCLES(3), .GAP_CYCLES(1)) dut3 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus3),
    .busy        (busy3),
    .tx_done     (tx_done3),
    .frame_count (frame_count3),
    .fifo_level  (fifo_level3)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: accepted words queue up in order, each comEn-high run is one
  // frame that a 32-bit receiver window turns back into a word.
  logic [31:0] expQ [$];
  logic        frameBits [$];
  int          modelLevel = 0;
  int          acceptCnt  = 0;
  logic [15:0] modelFrames = 16'd0;
  logic        pendPush  = 1'b0;
  logic        prevComEn = 1'b0;
  logic        seenFrame = 1'b0;
  int          gapLen     = 0;
  int          levelAtEnd = 0;
  logic [31:0] rxWord;

  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      frameBits.delete();
      modelLevel  = 0;
      acceptCnt   = 0;
      modelFrames = 16'd0;
      pendPush    = 1'b0;
      prevComEn   = 1'b0;
      seenFrame   = 1'b0;
      gapLen      = 0;
      levelAtEnd  = 0;
    end else begin
      if (pendPush) modelLevel++;
      if (bus.comEn && !prevComEn) modelLevel--;
      checkOutput("fifo_level", 32'(fifo_level), modelLevel);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(modelLevel < 4));

      if (bus.comEn) begin
        if (!prevComEn && seenFrame) begin
          checkOutput("gap_min", 32'(gapLen >= GAP), 1);
          if (levelAtEnd > 0) checkOutput("gap_exact", gapLen, GAP);
        end
        frameBits.push_back(bus.dataout);
        checkOutput("tx_done_in_frame", 32'(tx_done), 0);
      end else begin
        checkOutput("dataout_idle", 32'(bus.dataout), 0);
        if (prevComEn) begin
          modelFrames = modelFrames + 16'd1;
          checkOutput("tx_done_pulse", 32'(tx_done), 1);
          checkOutput("frame_count", 32'(frame_count), 32'(modelFrames));
          checkOutput("busy_in_gap", 32'(busy), 1);
          checkOutput("frame_len", frameBits.size(), 34);
          rxWord = 'x;
          if (frameBits.size() == 34) begin
            for (int i = 1; i <= 32; i++) rxWord = {rxWord[30:0], frameBits[i]};
            checkOutput("lead_bit", 32'(frameBits[0]), 0);
            checkOutput("trail_bit", 32'(frameBits[33]), 0);
          end
          checkOutput("frame_expected", 32'(expQ.size() > 0), 1);
          if (expQ.size() > 0) checkOutput("frame_data", rxWord, expQ.pop_front());
          frameBits.delete();
          seenFrame  = 1'b1;
          levelAtEnd = modelLevel;
          gapLen     = 1;
        end else begin
          checkOutput("tx_done_idle", 32'(tx_done), 0);
          gapLen++;
        end
      end

      prevComEn = bus.comEn;
      pendPush  = bus.in_valid && (modelLevel < 4);
      if (pendPush) begin
        expQ.push_back(bus.in_data);
        acceptCnt++;
      end
    end
  end

  // Presents one word for a single cycle; returns just after the sampling edge.
  task automatic applyStimulus(input logic [31:0] word);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (!(busy == 1'b0 && fifo_level == 3'd0 && bus.comEn == 1'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(n < budget), 1);
  endtask

  logic [31:0] b2bWords [4] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
  logic [31:0] word3;
  logic        bits3 [$];
  int          n, peak, holdBad, lowCnt, highCnt;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus3.in_valid = 1'b0;
    bus3.in_data  = 32'd0;

    // Reset values while reset is held
    @(posedge clk); #1;
    checkOutput("rst_comEn", 32'(bus.comEn), 0);
    checkOutput("rst_dataout", 32'(bus.dataout), 0);
    checkOutput("rst_tx_done", 32'(tx_done), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_count", 32'(frame_count), 0);
    checkOutput("rst_fifo_level", 32'(fifo_level), 0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word with exact cycle placement
    $display("[TB] single word");
    applyStimulus(32'hA5A5_0F0F);
    checkOutput("sw_comEn_E0", 32'(bus.comEn), 0);
    checkOutput("sw_level_E0", 32'(fifo_level), 1);
    checkOutput("sw_busy_E0", 32'(busy), 0);
    @(posedge clk); #1;
    checkOutput("sw_comEn_E1", 32'(bus.comEn), 1);
    checkOutput("sw_lead_E1", 32'(bus.dataout), 0);
    checkOutput("sw_busy_E1", 32'(busy), 1);
    @(posedge clk); #1;
    checkOutput("sw_bit31_E2", 32'(bus.dataout), 1);
    repeat (31) begin @(posedge clk); #1; end
    checkOutput("sw_bit0_E33", 32'(bus.dataout), 1);
    @(posedge clk); #1;
    checkOutput("sw_trail_comEn_E34", 32'(bus.comEn), 1);
    checkOutput("sw_trail_data_E34", 32'(bus.dataout), 0);
    @(posedge clk); #1;
    checkOutput("sw_comEn_E35", 32'(bus.comEn), 0);
    checkOutput("sw_tx_done_E35", 32'(tx_done), 1);
    checkOutput("sw_frame_count", 32'(frame_count), 1);
    @(posedge clk); #1;
    checkOutput("sw_tx_done_E36", 32'(tx_done), 0);
    waitIdle("sw", 50);

    // Back-to-back words on consecutive cycles
    $display("[TB] back-to-back");
    doReset();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b2bWords[i];
      @(posedge clk); #1;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    bus.in_valid = 1'b0;
    checkOutput("b2b_peak_level", peak, 3);
    waitIdle("b2b", 400);
    checkOutput("b2b_frame_count", 32'(frame_count), 4);
    checkOutput("b2b_all_delivered", expQ.size(), 0);

    // Overflow: hold valid while a frame is running
    $display("[TB] overflow");
    doReset();
    applyStimulus($urandom);
    @(posedge clk); #1;
    checkOutput("ovf_frame_active", 32'(bus.comEn), 1);
    repeat (5) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("ovf_level_full", 32'(fifo_level), 4);
    checkOutput("ovf_in_ready_low", 32'(bus.in_ready), 0);
    waitIdle("ovf", 600);
    checkOutput("ovf_frame_count", 32'(frame_count), 5);
    checkOutput("ovf_all_delivered", expQ.size(), 0);

    // Reset in the middle of a frame, with more words queued behind it
    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(32'h1357_9BDF);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1111_2222;
    @(posedge clk); #1;
    bus.in_data  = 32'h3333_4444;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    checkOutput("mid_bit15", 32'(bus.dataout), 1);
    checkOutput("mid_level_before", 32'(fifo_level), 2);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_comEn", 32'(bus.comEn), 0);
    checkOutput("mid_rst_dataout", 32'(bus.dataout), 0);
    checkOutput("mid_rst_level", 32'(fifo_level), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_tx_done", 32'(tx_done), 0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    highCnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.comEn) highCnt++;
    end
    checkOutput("mid_no_resume", highCnt, 0);
    applyStimulus(32'hDEAD_BEEF);
    waitIdle("mid", 60);
    checkOutput("mid_frame_count", 32'(frame_count), 1);
    checkOutput("mid_all_delivered", expQ.size(), 0);

    // Random push stream
    $display("[TB] random stream");
    doReset();
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    waitIdle("rnd", 400);
    checkOutput("rnd_frame_count", 32'(frame_count), 32'(acceptCnt[15:0]));
    checkOutput("rnd_all_delivered", expQ.size(), 0);

    // Slow instance: three clocks per slot, one-slot gap
    $display("[TB] BIT_CYCLES=3");
    bus3.in_valid = 1'b1;
    bus3.in_data  = 32'hC3C3_C3C3;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    n = 0;
    while (!bus3.comEn && n < 10) begin @(posedge clk); #1; n++; end
    checkOutput("bc3_start_latency", n, 1);
    n = 0;
    bits3.delete();
    while (bus3.comEn && n < 200) begin
      bits3.push_back(bus3.dataout);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bc3_comEn_high", n, 102);
    checkOutput("bc3_tx_done", 32'(tx_done3), 1);
    checkOutput("bc3_frame_count", 32'(frame_count3), 1);
    if (bits3.size() == 102) begin
      holdBad = 0;
      word3   = 32'd0;
      for (int s = 0; s < 34; s++) begin
        for (int c = 1; c < 3; c++) if (bits3[s*3+c] !== bits3[s*3]) holdBad++;
      end
      for (int s = 1; s <= 32; s++) word3 = {word3[30:0], bits3[s*3]};
      checkOutput("bc3_hold", holdBad, 0);
      checkOutput("bc3_word", word3, 32'hC3C3_C3C3);
      checkOutput("bc3_lead", 32'(bits3[0]), 0);
      checkOutput("bc3_trail", 32'(bits3[99]), 0);
    end
    lowCnt = 0;
    repeat (6) begin
      if (!bus3.comEn) lowCnt++;
      @(posedge clk); #1;
    end
    checkOutput("bc3_low_after", lowCnt, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
